// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared state encoding, op encodings and iteration count for mult_div.
package mult_div_pkg;
  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_FINISH} state_e;
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV = 1'b1;
  localparam int ITERS = 32;
endpackage

// File: rtl/mult_div.sv
// mult_div: iterative signed multiply (radix-2 Booth) / signed divide (restoring), one step per cycle.
// Ports: clk, reset (sync, active-high); start/op/srcA/srcB request; busy, done pulse, hi/lo result, div_zero flag.
module mult_div
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  localparam int W2 = 2 * WIDTH;
  state_e state_q, state_d;
  logic [5:0] cnt_q;
  logic [W2-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] m_q, hi_q, lo_q, mag_a, mag_b, res_hi, res_lo;
  logic qm1_q, qneg_q, rneg_q, dz_q, last, div0;
  logic [WIDTH:0] booth_sum, trial;
  assign mag_a = srcA[WIDTH-1] ? -srcA : srcA;
  assign mag_b = srcB[WIDTH-1] ? -srcB : srcB;
  assign last = cnt_q == 6'(ITERS - 1);
  assign div0 = state_q == S_DIV && m_q == '0;
  // Booth add/sub is done one bit wider so the most negative multiplicand cannot overflow.
  assign booth_sum = {acc_q[W2-1], acc_q[W2-1:WIDTH]}
                   + (({acc_q[0], qm1_q} == 2'b01) ? {m_q[WIDTH-1], m_q}
                   :  ({acc_q[0], qm1_q} == 2'b10) ? -{m_q[WIDTH-1], m_q} : '0);
  assign trial = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, m_q};
  always_comb begin
    acc_d = (state_q == S_DIV)
          ? (trial[WIDTH] ? {acc_q[W2-2:0], 1'b0} : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1})
          : {booth_sum[WIDTH:1], booth_sum[0], acc_q[WIDTH-1:1]};
    res_hi = (state_q == S_DIV && rneg_q) ? -acc_d[W2-1:WIDTH] : acc_d[W2-1:WIDTH];
    res_lo = (state_q == S_DIV && qneg_q) ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (op == OP_DIV) ? S_DIV : S_MULT;
      S_MULT: if (last) state_d = S_FINISH;
      S_DIV: if (div0 || last) state_d = S_FINISH;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    busy = state_q != S_IDLE;
    done = state_q == S_FINISH;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      m_q <= '0;
      cnt_q <= '0;
      qm1_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      acc_q <= {{WIDTH{1'b0}}, (op == OP_DIV) ? mag_a : srcB};
      m_q <= (op == OP_DIV) ? mag_b : srcA;
      cnt_q <= '0;
      qm1_q <= 1'b0;
      qneg_q <= srcA[WIDTH-1] ^ srcB[WIDTH-1];
      rneg_q <= srcA[WIDTH-1];
      dz_q <= 1'b0;
    end else if (state_q == S_MULT || state_q == S_DIV) begin
      acc_q <= acc_d;
      qm1_q <= acc_q[0];
      cnt_q <= cnt_q + 6'd1;
      if (div0) dz_q <= 1'b1;
      else if (last) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end
  assign hi = hi_q;
  assign lo = lo_q;
  assign div_zero = dz_q;
endmodule
